// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: requester-side and SPI-master-side signals of the arbiter
interface spi_master_arbiter_if #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]               SPI_ARBITER_req_InHigh;
  logic [NUM_REQ*DATAWIDTH_BUS-1:0] SPI_ARBITER_data_In;
  logic [NUM_REQ-1:0]               SPI_ARBITER_grant_Out;
  logic [NUM_REQ-1:0]               SPI_ARBITER_done_Out;
  logic                             SPI_ARBITER_error_Out;
  logic [DATAWIDTH_BUS-1:0]         SPI_ARBITER_rxData_Out;
  logic                             SPI_ARBITER_start_Out;
  logic [DATAWIDTH_BUS-1:0]         SPI_ARBITER_txData_Out;
  logic                             SPI_ARBITER_busy_In;
  logic                             SPI_ARBITER_newData_In;
  logic [DATAWIDTH_BUS-1:0]         SPI_ARBITER_rxData_In;
  modport master (
    input  SPI_ARBITER_req_InHigh, SPI_ARBITER_data_In, SPI_ARBITER_busy_In,
           SPI_ARBITER_newData_In, SPI_ARBITER_rxData_In,
    output SPI_ARBITER_grant_Out, SPI_ARBITER_done_Out, SPI_ARBITER_error_Out,
           SPI_ARBITER_rxData_Out, SPI_ARBITER_start_Out, SPI_ARBITER_txData_Out
  );
  modport slave (
    output SPI_ARBITER_req_InHigh, SPI_ARBITER_data_In, SPI_ARBITER_busy_In,
           SPI_ARBITER_newData_In, SPI_ARBITER_rxData_In,
    input  SPI_ARBITER_grant_Out, SPI_ARBITER_done_Out, SPI_ARBITER_error_Out,
           SPI_ARBITER_rxData_Out, SPI_ARBITER_start_Out, SPI_ARBITER_txData_Out
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI master among NUM_REQ requesters
module spi_master_arbiter #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic SPI_ARBITER_CLOCK_50,
  input logic SPI_ARBITER_RESET_InLow,
  spi_master_arbiter_if.master bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic error_q, error_d, start_q, start_d;
  logic [DATAWIDTH_BUS-1:0] rx_q, rx_d, tx_q, tx_d;
  logic [DATAWIDTH_BUS-1:0] data_arr [NUM_REQ];
  logic found;
  logic [PW-1:0] pick, idx, sel_nxt;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = bus.SPI_ARBITER_data_In[g*DATAWIDTH_BUS +: DATAWIDTH_BUS];
  end
  assign sel_nxt = PW'((int'(sel_q) + 1) % NUM_REQ);
  // first requester at or after the rotation pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && bus.SPI_ARBITER_req_InHigh[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  // transaction sequencing: grant, start pulse, wait for busy, wait for completion
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    grant_d = grant_q;
    done_d = '0;
    error_d = 1'b0;
    start_d = 1'b0;
    rx_d = rx_q;
    tx_d = tx_q;
    case (state_q)
      IDLE: if (found && !bus.SPI_ARBITER_busy_In) begin
        sel_d = pick;
        grant_d = NUM_REQ'(1) << pick;
        tx_d = data_arr[pick];
        start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (bus.SPI_ARBITER_busy_In) state_d = WAIT_DONE;
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        error_d = 1'b1;
        grant_d = '0;
        ptr_d = sel_nxt;
        state_d = IDLE;
      end else cnt_d = cnt_q + 1'b1;
      default: if (bus.SPI_ARBITER_newData_In || !bus.SPI_ARBITER_busy_In) begin
        rx_d = bus.SPI_ARBITER_rxData_In;
        done_d = grant_q;
        grant_d = '0;
        ptr_d = sel_nxt;
        state_d = IDLE;
      end
    endcase
  end
  // state and registered outputs, cleared immediately on reset
  always_ff @(posedge SPI_ARBITER_CLOCK_50 or negedge SPI_ARBITER_RESET_InLow) begin
    if (!SPI_ARBITER_RESET_InLow) begin
      state_q <= IDLE;
      ptr_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      grant_q <= '0;
      done_q <= '0;
      error_q <= 1'b0;
      start_q <= 1'b0;
      rx_q <= '0;
      tx_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      done_q <= done_d;
      error_q <= error_d;
      start_q <= start_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
    end
  end
  assign bus.SPI_ARBITER_grant_Out = grant_q;
  assign bus.SPI_ARBITER_done_Out = done_q;
  assign bus.SPI_ARBITER_error_Out = error_q;
  assign bus.SPI_ARBITER_rxData_Out = rx_q;
  assign bus.SPI_ARBITER_start_Out = start_q;
  assign bus.SPI_ARBITER_txData_Out = tx_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed stimulus, SPI master model and per-cycle reference check
module tb_spi_master_arbiter;
  localparam int DW = 8, N = 4, TO = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [DW-1:0] tx_bytes [N];
  logic force_busy = 1'b0, m_busy = 1'b0, m_new = 1'b0;
  logic [DW-1:0] m_rx_in = '0, m_rx = 8'h3C;
  int lat = 1, len = 2;
  bit dead = 0, nonewd = 0;
  int checks = 0, errors = 0;
  int owner = -1, ptr = 0, waited = 0;
  bit issued = 0, active = 0;
  logic [N-1:0] e_done = '0;
  logic e_err = 1'b0, e_start = 1'b0;
  logic [DW-1:0] e_rx = '0, e_tx = '0;
  logic [N-1:0] g, d;
  int n;
  spi_master_arbiter_if #(.DATAWIDTH_BUS(DW), .NUM_REQ(N)) bus();
  spi_master_arbiter #(.DATAWIDTH_BUS(DW), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .SPI_ARBITER_CLOCK_50(clk),
    .SPI_ARBITER_RESET_InLow(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.SPI_ARBITER_req_InHigh = req;
  assign bus.SPI_ARBITER_data_In = {tx_bytes[3], tx_bytes[2], tx_bytes[1], tx_bytes[0]};
  assign bus.SPI_ARBITER_busy_In = m_busy | force_busy;
  assign bus.SPI_ARBITER_newData_In = m_new;
  assign bus.SPI_ARBITER_rxData_In = m_rx_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_start(output logic [N-1:0] gr, output int cyc);
    bit seen = 0;
    cyc = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      seen = bus.SPI_ARBITER_start_Out;
    end
    check("start_seen", 32'(seen), 1);
    gr = bus.SPI_ARBITER_grant_Out;
  endtask

  task automatic wait_done(output logic [N-1:0] dn);
    int c = 0;
    dn = '0;
    while (dn == '0 && c < 60) begin
      @(negedge clk);
      c++;
      dn = bus.SPI_ARBITER_done_Out;
    end
    check("done_seen", 32'(dn != '0), 1);
  endtask

  // SPI master: busy rises lat cycles after start, ends with newData or a plain busy drop
  initial forever begin
    @(negedge clk);
    if (bus.SPI_ARBITER_start_Out && !dead) begin
      repeat (lat) @(posedge clk);
      #1 m_busy = 1'b1;
      repeat (len) @(posedge clk);
      #1 m_rx_in = m_rx;
      if (nonewd) m_busy = 1'b0;
      else m_new = 1'b1;
      @(posedge clk);
      #1 m_new = 1'b0;
      m_busy = 1'b0;
    end
  end

  // reference: owner of the shared master and where its exchange stands
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      owner = -1; ptr = 0; waited = 0; issued = 0; active = 0;
      e_done = '0; e_err = 1'b0; e_start = 1'b0; e_rx = '0; e_tx = '0;
    end else begin
      e_done = '0; e_err = 1'b0; e_start = 1'b0;
      if (owner < 0) begin
        if (req != '0 && !bus.SPI_ARBITER_busy_In) begin
          for (int k = 0; k < N; k++)
            if (owner < 0 && req[(ptr + k) % N]) owner = (ptr + k) % N;
          e_tx = tx_bytes[owner];
          e_start = 1'b1;
          issued = 0; active = 0; waited = 0;
        end
      end else if (!issued) issued = 1;
      else if (!active) begin
        if (bus.SPI_ARBITER_busy_In) active = 1;
        else begin
          waited++;
          if (waited == TO) begin
            e_err = 1'b1;
            ptr = (owner + 1) % N;
            owner = -1;
          end
        end
      end else if (bus.SPI_ARBITER_newData_In || !bus.SPI_ARBITER_busy_In) begin
        e_done = N'(1) << owner;
        e_rx = bus.SPI_ARBITER_rxData_In;
        ptr = (owner + 1) % N;
        owner = -1;
      end
    end
  end

  // every cycle, all outputs against the reference
  initial forever begin
    @(negedge clk);
    check("grant", 32'(bus.SPI_ARBITER_grant_Out), owner < 0 ? 0 : (1 << owner));
    check("done", 32'(bus.SPI_ARBITER_done_Out), 32'(e_done));
    check("error", 32'(bus.SPI_ARBITER_error_Out), 32'(e_err));
    check("start", 32'(bus.SPI_ARBITER_start_Out), 32'(e_start));
    check("rx", 32'(bus.SPI_ARBITER_rxData_Out), 32'(e_rx));
    check("tx", 32'(bus.SPI_ARBITER_txData_Out), 32'(e_tx));
  end

  initial begin
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    req = 4'b1111;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.SPI_ARBITER_grant_Out), 0);
    check("rst_start", 32'(bus.SPI_ARBITER_start_Out), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_start(g, n);
      check("rr_grant", 32'(g), 32'(1 << (k % 4)));
      if (k == 0) begin
        check("rst_grant_latency", n, 1);
        @(negedge clk);
        check("start_one_cycle", 32'(bus.SPI_ARBITER_start_Out), 0);
      end
      if (k == 7) req = '0;
    end
    wait_done(d);
    tx_bytes[2] = 8'hA5;
    req = 4'b0100;
    wait_start(g, n);
    check("single_grant", 32'(g), 32'h4);
    check("single_tx", 32'(bus.SPI_ARBITER_txData_Out), 32'hA5);
    req = '0;
    wait_done(d);
    check("single_done", 32'(d), 32'h4);
    check("single_rx", 32'(bus.SPI_ARBITER_rxData_Out), 32'h3C);
    @(negedge clk);
    check("single_grant_clr", 32'(bus.SPI_ARBITER_grant_Out), 0);
    check("single_done_pulse", 32'(bus.SPI_ARBITER_done_Out), 0);
    req = 4'b0001;
    wait_start(g, n);
    check("skip_first", 32'(g), 32'h1);
    req = '0;
    wait_done(d);
    req = 4'b1001;
    wait_start(g, n);
    check("skip_to_3", 32'(g), 32'h8);
    wait_start(g, n);
    check("skip_wrap_0", 32'(g), 32'h1);
    req = '0;
    wait_done(d);
    dead = 1;
    req = 4'b0010;
    wait_start(g, n);
    check("to_grant", 32'(g), 32'h2);
    req = '0;
    n = 0;
    while (!bus.SPI_ARBITER_error_Out && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("to_error_seen", 32'(bus.SPI_ARBITER_error_Out), 1);
    check("to_latency", n, 17);
    check("to_no_done", 32'(bus.SPI_ARBITER_done_Out), 0);
    check("to_grant_clr", 32'(bus.SPI_ARBITER_grant_Out), 0);
    @(negedge clk);
    check("to_error_pulse", 32'(bus.SPI_ARBITER_error_Out), 0);
    dead = 0;
    req = 4'b1011;
    wait_start(g, n);
    check("to_ptr_2", 32'(g), 32'h8);
    req = '0;
    wait_done(d);
    force_busy = 1'b1;
    req = 4'b0001;
    repeat (5) @(negedge clk);
    check("busy_block", 32'(bus.SPI_ARBITER_grant_Out), 0);
    force_busy = 1'b0;
    wait_start(g, n);
    check("busy_release", 32'(g), 32'h1);
    req = '0;
    wait_done(d);
    nonewd = 1;
    m_rx = 8'h5A;
    req = 4'b0100;
    wait_start(g, n);
    check("fall_grant", 32'(g), 32'h4);
    req = '0;
    wait_done(d);
    check("fall_done", 32'(d), 32'h4);
    check("fall_rx", 32'(bus.SPI_ARBITER_rxData_Out), 32'h5A);
    nonewd = 0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
